mem_access_sequencer: RTL and testbench

Sequences the LC-3 memory-access datapath on behalf of the main control FSM. It drives the load enables of the 16-bit MAR/MDR/IR/PC registers, the PC mux and MDR mux selects, the bus gates, and the SRAM enables. It runs the instruction fetch, data load and data store micro-sequences, including a configurable SRAM wait-state count. The main FSM issues one request, waits for Done, then continues decode/execute.

---
 rtl/mem_access_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Memory-access sequencer for the LC-3 datapath: runs fetch, load and store
// micro-sequences on request from the main control FSM. Outputs are a pure
// decode of the registered state and wait counter.
module mem_access_sequencer #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_fetch,
  input  logic       i_req_load,
  input  logic       i_req_store,
  input  logic       i_halt,
  output logic       o_ld_mar,
  output logic       o_ld_mdr,
  output logic       o_ld_ir,
  output logic       o_ld_pc,
  output logic       o_gate_pc,
  output logic       o_gate_mdr,
  output logic [1:0] o_pc_sel,
  output logic       o_mdr_sel,
  output logic       o_mem_en,
  output logic       o_mem_we,
  output logic       o_busy,
  output logic       o_done
);

  // state  | meaning
  // IDLE   | waiting for a request; requests sampled only here
  // F_MAR  | PC onto bus into MAR, PC <= PC+1
  // ADDR   | requester address into MAR (load/store)
  // RD     | SRAM read; MDR loads in the final cycle
  // F_IR   | MDR onto bus into IR
  // MDRLD  | bus data into MDR (store)
  // WR     | SRAM write
  // DONE   | one-cycle completion pulse

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_F_MAR = 3'd1,
    S_ADDR  = 3'd2,
    S_RD    = 3'd3,
    S_F_IR  = 3'd4,
    S_MDRLD = 3'd5,
    S_WR    = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_FETCH = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_op;
  logic [1:0] w_op_next;
  logic [3:0] r_cnt;
  logic       w_cnt_zero;
  logic       w_cnt_load;
  logic       w_in_mem;

  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_in_mem   = (r_state == S_RD) || (r_state == S_WR);
  // Counter reloads only when stepping into RD or WR from another state.
  assign w_cnt_load = ((w_state_next == S_RD) || (w_state_next == S_WR)) &&
                      (w_state_next != r_state);

  // State, op code and wait counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NONE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      if (w_cnt_load) begin
        r_cnt <= C_WAIT;
      end else if (w_in_mem && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Request arbitration in IDLE (Fetch > Load > Store) latches the op code
  always_comb begin
    w_op_next = r_op;
    if ((r_state == S_IDLE) && !i_halt) begin
      if (i_req_fetch) begin
        w_op_next = OP_FETCH;
      end else if (i_req_load) begin
        w_op_next = OP_LOAD;
      end else if (i_req_store) begin
        w_op_next = OP_STORE;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
        if (!i_halt) begin
          if (i_req_fetch) begin
            w_state_next = S_F_MAR;
          end else if (i_req_load || i_req_store) begin
            w_state_next = S_ADDR;
          end
        end
      end
      S_F_MAR: w_state_next = S_RD;
      S_ADDR: begin
        if (r_op == OP_STORE) begin
          w_state_next = S_MDRLD;
        end else if (r_op == OP_LOAD) begin
          w_state_next = S_RD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RD: begin
        if (!w_cnt_zero) begin
          w_state_next = S_RD;
        end else if (r_op == OP_FETCH) begin
          w_state_next = S_F_IR;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_F_IR:  w_state_next = S_DONE;
      S_MDRLD: w_state_next = S_WR;
      S_WR:    w_state_next = w_cnt_zero ? S_DONE : S_WR;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore output decode from registered state and counter
  always_comb begin
    o_ld_mar   = 1'b0;
    o_ld_mdr   = 1'b0;
    o_ld_ir    = 1'b0;
    o_ld_pc    = 1'b0;
    o_gate_pc  = 1'b0;
    o_gate_mdr = 1'b0;
    o_pc_sel   = 2'b00;
    o_mdr_sel  = 1'b0;
    o_mem_en   = 1'b0;
    o_mem_we   = 1'b0;
    o_busy     = (r_state != S_IDLE);
    o_done     = 1'b0;
    case (r_state)
      S_F_MAR: begin
        o_gate_pc = 1'b1;
        o_ld_mar  = 1'b1;
        o_ld_pc   = 1'b1;
      end
      S_ADDR: o_ld_mar = 1'b1;
      S_RD: begin
        o_mem_en = 1'b1;
        o_ld_mdr = w_cnt_zero;
      end
      S_F_IR: begin
        o_gate_mdr = 1'b1;
        o_ld_ir    = 1'b1;
      end
      S_MDRLD: begin
        o_mdr_sel = 1'b1;
        o_ld_mdr  = 1'b1;
      end
      S_WR: begin
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer. Four instances with WAIT_STATES of
// 2, 0, 3 and 15 share the same stimulus; each step checks one instance.
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic req_fetch, req_load, req_store, halt;

  // {ld_mar, ld_mdr, ld_ir, ld_pc, gate_pc, gate_mdr, pc_sel[1:0],
  //  mdr_sel, mem_en, mem_we, busy, done}
  logic [12:0] obs [4];

  localparam logic [12:0] E_IDLE  = 13'b0000_00_00_00000;
  localparam logic [12:0] E_FMAR  = 13'b1001_10_00_00010;
  localparam logic [12:0] E_RD    = 13'b0000_00_00_01010;
  localparam logic [12:0] E_RDL   = 13'b0100_00_00_01010;
  localparam logic [12:0] E_FIR   = 13'b0010_01_00_00010;
  localparam logic [12:0] E_ADDR  = 13'b1000_00_00_00010;
  localparam logic [12:0] E_MDRLD = 13'b0100_00_00_10010;
  localparam logic [12:0] E_WR    = 13'b0000_00_00_01110;
  localparam logic [12:0] E_DONE  = 13'b0000_00_00_00011;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int unsigned ws_of(input int g);
    case (g)
      0: return 2;
      1: return 0;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, gate_pc, gate_mdr;
    logic [1:0] pc_sel;
    logic       mdr_sel, mem_en, mem_we, busy, done;

    mem_access_sequencer #(.WAIT_STATES(ws_of(g))) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_fetch(req_fetch),
      .i_req_load (req_load),
      .i_req_store(req_store),
      .i_halt     (halt),
      .o_ld_mar   (ld_mar),
      .o_ld_mdr   (ld_mdr),
      .o_ld_ir    (ld_ir),
      .o_ld_pc    (ld_pc),
      .o_gate_pc  (gate_pc),
      .o_gate_mdr (gate_mdr),
      .o_pc_sel   (pc_sel),
      .o_mdr_sel  (mdr_sel),
      .o_mem_en   (mem_en),
      .o_mem_we   (mem_we),
      .o_busy     (busy),
      .o_done     (done)
    );

    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_pc, gate_pc, gate_mdr, pc_sel,
                     mdr_sel, mem_en, mem_we, busy, done};
  end

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int k, input logic [12:0] exp, input string tag);
    n_cmp++;
    assert (obs[k] === exp) else begin
      n_err++;
      $error("FAIL %s inst%0d: observed=%b expected=%b", tag, k, obs[k], exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drain();
    req_fetch = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
    halt      = 1'b0;
    repeat (40) step();
  endtask

  initial begin
    int n_en;
    int n_done;
    int done_at;

    rst_n = 1'b0;
    req_fetch = 1'b0; req_load = 1'b0; req_store = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk(k, E_IDLE, "reset");
    rst_n = 1'b1;
    step();

    // Fetch, WAIT_STATES=2, with requests toggled while busy
    req_fetch = 1'b1;
    chk(0, E_IDLE, "fetch_c0");
    step(); req_fetch = 1'b0;
    chk(0, E_FMAR, "fetch_c1");
    req_load = 1'b1;
    step(); chk(0, E_RD, "fetch_c2");
    req_load = 1'b0; req_store = 1'b1;
    step(); chk(0, E_RD, "fetch_c3");
    req_fetch = 1'b1;
    step(); chk(0, E_RDL, "fetch_c4");
    req_fetch = 1'b0; req_store = 1'b0;
    step(); chk(0, E_FIR, "fetch_c5");
    step(); chk(0, E_DONE, "fetch_c6");
    step(); chk(0, E_IDLE, "fetch_c7");
    drain();

    // Load, WAIT_STATES=0
    req_load = 1'b1;
    step(); req_load = 1'b0;
    chk(1, E_ADDR, "load_c1");
    step(); chk(1, E_RDL, "load_c2");
    step(); chk(1, E_DONE, "load_c3");
    step(); chk(1, E_IDLE, "load_c4");
    drain();

    // Store, WAIT_STATES=3
    req_store = 1'b1;
    step(); req_store = 1'b0;
    chk(2, E_ADDR, "store_c1");
    step(); chk(2, E_MDRLD, "store_c2");
    for (int c = 3; c <= 6; c++) begin
      step(); chk(2, E_WR, "store_wr");
    end
    step(); chk(2, E_DONE, "store_c7");
    step(); chk(2, E_IDLE, "store_c8");
    drain();

    // All requests at once: fetch wins; held load follows after Done
    req_fetch = 1'b1; req_load = 1'b1; req_store = 1'b1;
    step(); req_fetch = 1'b0; req_store = 1'b0;
    chk(0, E_FMAR, "prio_c1");
    step(); chk(0, E_RD,   "prio_c2");
    step(); chk(0, E_RD,   "prio_c3");
    step(); chk(0, E_RDL,  "prio_c4");
    step(); chk(0, E_FIR,  "prio_c5");
    step(); chk(0, E_DONE, "prio_c6");
    step(); chk(0, E_IDLE, "prio_c7");
    step(); chk(0, E_ADDR, "prio_load_c8");
    step(); chk(0, E_RD,   "prio_load_c9");
    drain();

    // Halt blocks every request
    halt = 1'b1; req_fetch = 1'b1; req_load = 1'b1; req_store = 1'b1;
    repeat (20) begin
      step();
      for (int k = 0; k < 4; k++) chk(k, E_IDLE, "halt");
    end
    drain();

    // WAIT_STATES=15 read: Mem_En for exactly 16 cycles, Done at cycle 18
    req_load = 1'b1;
    step(); req_load = 1'b0;
    n_en = 0; n_done = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (obs[3][3]) n_en++;
      if (obs[3][0]) begin
        n_done++;
        done_at = c;
      end
      step();
    end
    chk_int(n_en, 16, "ws15_mem_en_cycles");
    chk_int(n_done, 1, "ws15_done_count");
    chk_int(done_at, 18, "ws15_done_cycle");
    drain();

    // Reset asserted mid-RD of a fetch
    req_fetch = 1'b1;
    step(); req_fetch = 1'b0;
    chk(0, E_FMAR, "rst_fetch_c1");
    step(); chk(0, E_RD, "rst_fetch_c2");
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk(k, E_IDLE, "rst_async");
    step(); step();
    rst_n = 1'b1;
    n_done = 0;
    repeat (10) begin
      step();
      if (obs[0][0]) n_done++;
    end
    chk_int(n_done, 0, "rst_no_done");
    req_fetch = 1'b1;
    step(); req_fetch = 1'b0;
    chk(0, E_FMAR, "refetch_c1");
    step(); chk(0, E_RD,   "refetch_c2");
    step(); chk(0, E_RD,   "refetch_c3");
    step(); chk(0, E_RDL,  "refetch_c4");
    step(); chk(0, E_FIR,  "refetch_c5");
    step(); chk(0, E_DONE, "refetch_c6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
